// File: rtl/mov_up_seq.sv
// mov_up_seq: sequential "up" mover for the 2048 core, one column per cycle.
// Optional merge scoring is enabled by defining MOV_UP_SCORE_EN.
module mov_up_seq #(
    parameter int WIN_EXP = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [0:3][0:3][3:0]   grid_in,
    output logic                   busy,
    output logic                   done,
    output logic [0:3][0:3][3:0]   grid_out,
    output logic                   moved,
    output logic                   win,
    output logic [17:0]            score_add
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COL,
        S_DONE
    } state_t;

    typedef logic [0:3][3:0] col_t;

    localparam logic [3:0] WIN_E = 4'(WIN_EXP);

    // exponent 15 never merges so the +1 cannot wrap
    function automatic logic can_merge(input logic [3:0] a, input logic [3:0] b);
        return (a != 4'd0) && (a == b) && (a != 4'hF);
    endfunction

    function automatic col_t compact(input col_t v);
        col_t       o;
        logic [1:0] k;
        o = '0;
        k = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] != 4'd0) begin
                o[k] = v[i];
                k    = k + 2'd1;
            end
        end
        return o;
    endfunction

    // input is already compacted, so the row 0..2 scan reduces to three cases
    function automatic col_t merge(input col_t v);
        col_t o;
        o = v;
        if (can_merge(o[0], o[1])) begin
            o[0] = o[0] + 4'd1;
            o[1] = 4'd0;
            if (can_merge(o[2], o[3])) begin
                o[2] = o[2] + 4'd1;
                o[3] = 4'd0;
            end
        end else if (can_merge(o[1], o[2])) begin
            o[1] = o[1] + 4'd1;
            o[2] = 4'd0;
        end else if (can_merge(o[2], o[3])) begin
            o[2] = o[2] + 4'd1;
            o[3] = 4'd0;
        end
        return o;
    endfunction

    state_t               state_q, state_d;
    logic [1:0]           c_q, c_d;
    logic [0:3][0:3][3:0] grid_q, grid_d;
    logic [0:3][0:3][3:0] grid_out_q, grid_out_d;
    logic                 moved_q, moved_d;
    logic                 win_q, win_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    col_t col_in;
    col_t col_cmp;
    col_t col_res;
    logic col_moved;
    logic col_win;

    // slide the current column: compact, merge, compact
    always_comb begin
        col_in    = grid_q[c_q];
        col_cmp   = compact(col_in);
        col_res   = compact(merge(col_cmp));
        col_moved = (col_res != col_in);
        col_win   = (col_res[0] >= WIN_E) || (col_res[1] >= WIN_E) ||
                    (col_res[2] >= WIN_E) || (col_res[3] >= WIN_E);
    end

    // next-state and datapath updates for the move sequencer
    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        grid_d     = grid_q;
        grid_out_d = grid_out_q;
        moved_d    = moved_q;
        win_d      = win_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (done_q) begin
                    busy_d = 1'b0;
                end else if (start) begin
                    grid_d  = grid_in;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy_d  = 1'b1;
                moved_d = 1'b0;
                win_d   = 1'b0;
                c_d     = 2'd0;
                state_d = S_COL;
            end
            S_COL: begin
                grid_out_d[c_q] = col_res;
                moved_d         = moved_q | col_moved;
                win_d           = win_q | col_win;
                c_d             = c_q + 2'd1;
                if (c_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            c_q        <= 2'd0;
            grid_q     <= '0;
            grid_out_q <= '0;
            moved_q    <= 1'b0;
            win_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            grid_q     <= grid_d;
            grid_out_q <= grid_out_d;
            moved_q    <= moved_d;
            win_q      <= win_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign grid_out = grid_out_q;
    assign moved    = moved_q;
    assign win      = win_q;

`ifdef MOV_UP_SCORE_EN
    logic [17:0] score_q, score_d;
    logic [17:0] col_pts;

    function automatic logic [17:0] pts(input logic [3:0] e);
        return 18'd1 << (e + 4'd1);
    endfunction

    // points for the merges in the current column, same order as merge()
    always_comb begin
        col_pts = '0;
        if (can_merge(col_cmp[0], col_cmp[1])) begin
            col_pts = pts(col_cmp[0]);
            if (can_merge(col_cmp[2], col_cmp[3])) begin
                col_pts = col_pts + pts(col_cmp[2]);
            end
        end else if (can_merge(col_cmp[1], col_cmp[2])) begin
            col_pts = pts(col_cmp[1]);
        end else if (can_merge(col_cmp[2], col_cmp[3])) begin
            col_pts = pts(col_cmp[2]);
        end
    end

    // score accumulator: cleared in LOAD, summed per column
    always_comb begin
        score_d = score_q;
        if (state_q == S_LOAD) begin
            score_d = '0;
        end else if (state_q == S_COL) begin
            score_d = score_q + col_pts;
        end
    end

    // score register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score_add = score_q;
`else
    assign score_add = '0;
`endif

endmodule

// File: tb/tb_mov_up_seq.sv
// tb_mov_up_seq: scoreboard bench for the sequential up mover.
// Expected score follows MOV_UP_SCORE_EN.
module tb_mov_up_seq;

    typedef logic [0:3][0:3][3:0] grid_t;

    typedef struct {
        grid_t       g;
        logic        mv;
        logic        w;
        logic [17:0] sc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    grid_t       grid_in;
    logic        busy;
    logic        done;
    grid_t       grid_out;
    logic        moved;
    logic        win;
    logic [17:0] score_add;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    exp_t sb[$];

    mov_up_seq #(.WIN_EXP(11)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .grid_in   (grid_in),
        .busy      (busy),
        .done      (done),
        .grid_out  (grid_out),
        .moved     (moved),
        .win       (win),
        .score_add (score_add)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference: classic list-based 2048 slide toward row 0
    function automatic exp_t model(input grid_t g);
        exp_t e;
        int   t[$];
        int   o[$];
        int   i;
        int   sc;
        e.g  = '0;
        e.w  = 1'b0;
        sc   = 0;
        for (int c = 0; c < 4; c++) begin
            t.delete();
            o.delete();
            for (int r = 0; r < 4; r++)
                if (g[c][r] != 4'd0) t.push_back(int'(g[c][r]));
            i = 0;
            while (i < t.size()) begin
                if (i + 1 < t.size() && t[i] == t[i+1] && t[i] < 15) begin
                    o.push_back(t[i] + 1);
                    sc += 1 << (t[i] + 1);
                    i += 2;
                end else begin
                    o.push_back(t[i]);
                    i += 1;
                end
            end
            while (o.size() < 4) o.push_back(0);
            for (int r = 0; r < 4; r++) begin
                e.g[c][r] = 4'(o[r]);
                if (o[r] >= 11) e.w = 1'b1;
            end
        end
        e.mv = (e.g != g);
`ifdef MOV_UP_SCORE_EN
        e.sc = 18'(sc);
`else
        e.sc = '0;
`endif
        return e;
    endfunction

    function automatic grid_t set_col(input grid_t g, input int c,
                                      input int a, input int b,
                                      input int x, input int y);
        grid_t o;
        o       = g;
        o[c][0] = 4'(a);
        o[c][1] = 4'(b);
        o[c][2] = 4'(x);
        o[c][3] = 4'(y);
        return o;
    endfunction

    // compare every done result against the oldest expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("grid",  grid_out,  e.g);
                chk("moved", moved,     e.mv);
                chk("win",   win,       e.w);
                chk("score", score_add, e.sc);
            end
        end
    end

    task automatic do_move(input grid_t g, input bit hold);
        int cnt;
        @(negedge clk);
        grid_in = g;
        start   = 1'b1;
        sb.push_back(model(g));
        @(posedge clk);
        #1;
        if (hold) grid_in = grid_t'({$urandom(), $urandom()});
        else start = 1'b0;
        cnt = 0;
        while (!done && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        start = 1'b0;
        chk("latency", cnt, 6);
        chk("busy_at_done", busy, 1);
        @(posedge clk);
        #1;
        chk("done_pulse", done, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        grid_t g;
        int    d0;
        rst_n   = 1'b0;
        start   = 1'b0;
        grid_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  busy,      0);
        chk("rst_done",  done,      0);
        chk("rst_grid",  grid_out,  0);
        chk("rst_moved", moved,     0);
        chk("rst_win",   win,       0);
        chk("rst_score", score_add, 0);
        rst_n = 1'b1;

        do_move(set_col('0, 0, 1, 1, 1, 1), 1'b0);
        do_move(set_col('0, 2, 0, 3, 0, 3), 1'b0);
        g = '0;
        for (int c = 0; c < 4; c++) g = set_col(g, c, 1, 2, 3, 4);
        do_move(g, 1'b0);
        do_move(set_col(set_col('0, 1, 10, 10, 0, 0), 3, 15, 15, 0, 0), 1'b0);
        do_move('0, 1'b0);
        do_move(set_col('0, 0, 0, 2, 2, 2), 1'b0);
        do_move(set_col('0, 3, 14, 14, 14, 14), 1'b0);
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    g[c][r] = 4'($urandom_range(0, 3));
            do_move(g, 1'b0);
        end

        d0 = n_done;
        do_move(set_col('0, 2, 5, 5, 6, 6), 1'b1);
        repeat (8) @(posedge clk);
        #1;
        chk("hold_one_done", n_done - d0, 1);
        chk("hold_idle", busy, 0);

        @(negedge clk);
        grid_in = set_col('0, 1, 2, 2, 0, 0);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  busy,      0);
        chk("abort_done",  done,      0);
        chk("abort_grid",  grid_out,  0);
        chk("abort_moved", moved,     0);
        chk("abort_win",   win,       0);
        chk("abort_score", score_add, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_move(set_col('0, 0, 0, 0, 4, 4), 1'b0);

        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
